// File: rtl/dut_chk_pkg.sv
// Shared types and default widths for the dut response checker.
package dut_chk_pkg;

    localparam int CHK_OUT_W  = 30;
    localparam int CHK_IDX_W  = 16;
    localparam int CHK_LOG_AW = 4;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } chk_state_e;

    // One mismatch log entry: failing vector index plus masked XOR.
    typedef struct packed {
        logic [CHK_IDX_W-1:0] idx;
        logic [CHK_OUT_W-1:0] diff;
    } log_rec_t;

endpackage

// File: rtl/chk_sync_fifo.sv
// First-word-fall-through synchronous FIFO with occupancy count.
module chk_sync_fifo #(
    parameter int W  = 8,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr_i,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [W-1:0]  wdata_i,
    output logic [W-1:0]  rdata_o,
    output logic          empty_o,
    output logic [AW:0]   count_o
);

    localparam int DEPTH = 1 << AW;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic          do_push;
    logic          do_pop;

    // A pop on empty is dropped; a push while full only lands alongside a pop.
    assign do_pop  = pop_i && (count_q != '0);
    assign do_push = push_i && ((count_q != (AW+1)'(DEPTH)) || do_pop);

    // Storage array, no reset needed since reads are gated by empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clr_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule

// File: rtl/dut_response_checker.sv
// On-the-fly comparison of dut responses against golden vectors with a
// mismatch log FIFO, run counters and first-failure capture.
module dut_response_checker
    import dut_chk_pkg::*;
#(
    parameter int OUT_W  = CHK_OUT_W,
    parameter int IDX_W  = CHK_IDX_W,
    parameter int LOG_AW = CHK_LOG_AW
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_last,
    input  logic [OUT_W-1:0] dut_out,
    input  logic [OUT_W-1:0] exp_out,
    input  logic [OUT_W-1:0] care_mask,
    output logic             log_valid,
    input  logic             log_ready,
    output logic [IDX_W-1:0] log_idx,
    output logic [OUT_W-1:0] log_diff,
    output logic [IDX_W-1:0] vec_count,
    output logic [IDX_W-1:0] err_count,
    output logic             first_err_valid,
    output logic [IDX_W-1:0] first_err_idx,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             overflow
);

    localparam int DEPTH = 1 << LOG_AW;
    localparam int RW    = IDX_W + OUT_W;
    localparam int PW    = LOG_AW + 2;

    chk_state_e       state_q;
    logic             s1_v_q, s2_v_q;
    logic [OUT_W-1:0] s1_diff_q, s2_diff_q;
    logic [IDX_W-1:0] s1_idx_q, s2_idx_q;
    logic [IDX_W-1:0] vec_count_q, err_count_q, first_err_idx_q;
    logic             first_err_valid_q, overflow_q, done_q, pass_q;

    logic [LOG_AW:0]  fifo_count;
    logic             fifo_empty;
    logic [RW-1:0]    fifo_rdata;
    logic [PW-1:0]    pending;
    logic             ready, accept, start_go, push;

    // In-flight pipeline entries reserve FIFO slots so no record is ever dropped.
    assign pending  = PW'(fifo_count) + PW'(s1_v_q) + PW'(s2_v_q);
    assign ready    = (state_q == RUN) && (pending < PW'(DEPTH));
    assign accept   = in_valid && ready;
    assign start_go = start && ((state_q == IDLE) || (state_q == DONE));
    assign push     = s2_v_q && (s2_diff_q != '0);

    chk_sync_fifo #(
        .W  (RW),
        .AW (LOG_AW)
    ) u_log_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (start_go),
        .push_i  (push),
        .pop_i   (log_ready),
        .wdata_i ({s2_idx_q, s2_diff_q}),
        .rdata_o (fifo_rdata),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // Run FSM, compare pipeline, counters and first-failure capture.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q           <= IDLE;
            s1_v_q            <= 1'b0;
            s2_v_q            <= 1'b0;
            s1_diff_q         <= '0;
            s2_diff_q         <= '0;
            s1_idx_q          <= '0;
            s2_idx_q          <= '0;
            vec_count_q       <= '0;
            err_count_q       <= '0;
            first_err_idx_q   <= '0;
            first_err_valid_q <= 1'b0;
            overflow_q        <= 1'b0;
            done_q            <= 1'b0;
            pass_q            <= 1'b0;
        end else begin
            done_q <= 1'b0;

            s1_v_q <= accept;
            if (accept) begin
                s1_diff_q <= (dut_out ^ exp_out) & care_mask;
                s1_idx_q  <= vec_count_q;
            end
            s2_v_q    <= s1_v_q;
            s2_diff_q <= s1_diff_q;
            s2_idx_q  <= s1_idx_q;

            if (push) begin
                if (err_count_q != '1) begin
                    err_count_q <= err_count_q + IDX_W'(1);
                end
                if (!first_err_valid_q) begin
                    first_err_valid_q <= 1'b1;
                    first_err_idx_q   <= s2_idx_q;
                end
            end

            if (accept) begin
                if (vec_count_q == '1) begin
                    overflow_q <= 1'b1;
                end else begin
                    vec_count_q <= vec_count_q + IDX_W'(1);
                end
            end

            case (state_q)
                IDLE: begin
                    if (start) state_q <= RUN;
                end
                RUN: begin
                    if (accept && in_last) state_q <= DRAIN;
                end
                DRAIN: begin
                    // Both stages empty means err_count already holds its final value.
                    if (!s1_v_q && !s2_v_q) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                        pass_q  <= (err_count_q == '0) && !overflow_q;
                    end
                end
                DONE: begin
                    if (start) state_q <= RUN;
                end
                default: state_q <= IDLE;
            endcase

            if (start_go) begin
                vec_count_q       <= '0;
                err_count_q       <= '0;
                first_err_idx_q   <= '0;
                first_err_valid_q <= 1'b0;
                overflow_q        <= 1'b0;
                pass_q            <= 1'b0;
            end
        end
    end

    assign in_ready        = ready;
    assign log_valid       = !fifo_empty;
    assign log_idx         = fifo_empty ? '0 : fifo_rdata[RW-1:OUT_W];
    assign log_diff        = fifo_empty ? '0 : fifo_rdata[OUT_W-1:0];
    assign vec_count       = vec_count_q;
    assign err_count       = err_count_q;
    assign first_err_valid = first_err_valid_q;
    assign first_err_idx   = first_err_idx_q;
    assign busy            = (state_q == RUN) || (state_q == DRAIN);
    assign done            = done_q;
    assign pass            = pass_q;
    assign overflow        = overflow_q;

endmodule

// File: tb/tb_dut_response_checker.sv
// Self-checking bench for dut_response_checker: directed scenarios plus
// randomized runs against a queue-based reference model.
module tb_dut_response_checker;
    import dut_chk_pkg::*;

    localparam int OW = 30;
    localparam int IW = 16;

    logic          clk = 1'b0;
    logic          rst_n, start, in_valid, in_ready, in_last;
    logic [OW-1:0] dut_out, exp_out, care_mask;
    logic          log_valid, log_ready;
    logic [IW-1:0] log_idx;
    logic [OW-1:0] log_diff;
    logic [IW-1:0] vec_count, err_count, first_err_idx;
    logic          first_err_valid, busy, done, pass, overflow;

    dut_response_checker #(
        .OUT_W  (OW),
        .IDX_W  (IW),
        .LOG_AW (4)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_last         (in_last),
        .dut_out         (dut_out),
        .exp_out         (exp_out),
        .care_mask       (care_mask),
        .log_valid       (log_valid),
        .log_ready       (log_ready),
        .log_idx         (log_idx),
        .log_diff        (log_diff),
        .vec_count       (vec_count),
        .err_count       (err_count),
        .first_err_valid (first_err_valid),
        .first_err_idx   (first_err_idx),
        .busy            (busy),
        .done            (done),
        .pass            (pass),
        .overflow        (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [OW-1:0] d;
        logic [OW-1:0] e;
        logic [OW-1:0] m;
    } vec_t;

    vec_t        run_q[$];
    log_rec_t    got_q[$];
    log_rec_t    m_recs[$];
    int          checks = 0;
    int          errors = 0;
    int unsigned m_err, m_fidx;
    bit          m_fv, m_pass;

    // Records leave the FIFO at the posedge following a negedge with valid&ready.
    always @(negedge clk) begin
        if (rst_n && log_valid && log_ready) got_q.push_back({log_idx, log_diff});
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    // Reference model: a vector fails when any cared-about bit differs.
    task automatic compute_model();
        logic [OW-1:0] diff;
        m_recs.delete();
        m_err = 0; m_fv = 0; m_fidx = 0;
        foreach (run_q[i]) begin
            diff = (run_q[i].d ^ run_q[i].e) & run_q[i].m;
            if (diff != 0) begin
                m_recs.push_back('{idx: IW'(i), diff: diff});
                m_err++;
                if (!m_fv) begin m_fv = 1; m_fidx = i; end
            end
        end
        m_pass = (m_err == 0);
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_start();
        start = 1'b1; tick(); start = 1'b0;
    endtask

    task automatic send_vec(input vec_t v, input bit last);
        int n = 0;
        in_valid = 1'b1; dut_out = v.d; exp_out = v.e; care_mask = v.m; in_last = last;
        while (in_ready !== 1'b1 && n < 400) begin tick(); n++; end
        if (in_ready !== 1'b1) begin
            checks++; errors++;
            $display("FAIL send_timeout in_ready=%b required 1", in_ready);
        end else begin
            tick();
        end
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic send_run(input int gap_max);
        for (int i = 0; i < run_q.size(); i++) begin
            send_vec(run_q[i], i == run_q.size() - 1);
            if (i != run_q.size() - 1) repeat ($urandom_range(0, gap_max)) tick();
        end
    endtask

    task automatic wait_done(output bit seen);
        int n = 0;
        while (done !== 1'b1 && n < 100) begin tick(); n++; end
        seen = (done === 1'b1);
    endtask

    task automatic drain_log();
        int n = 0;
        log_ready = 1'b1;
        while (log_valid === 1'b1 && n < 64) begin tick(); n++; end
        tick();
        log_ready = 1'b0;
    endtask

    function automatic vec_t mk_vec(input logic [OW-1:0] flip, input logic [OW-1:0] m);
        vec_t v;
        v.d = OW'($urandom);
        v.e = v.d ^ flip;
        v.m = m;
        return v;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        checks++; if ({in_ready, log_valid, busy, done, pass, overflow, first_err_valid} !== 7'b0) begin
            errors++; $display("FAIL reset_flags got %b required 0000000",
                {in_ready, log_valid, busy, done, pass, overflow, first_err_valid});
        end
        checks++; if (vec_count !== '0 || err_count !== '0 || first_err_idx !== '0) begin
            errors++; $display("FAIL reset_counts got %0h/%0h/%0h required 0/0/0", vec_count, err_count, first_err_idx);
        end
        checks++; if (log_idx !== '0 || log_diff !== '0) begin
            errors++; $display("FAIL reset_log got %0h/%0h required 0/0", log_idx, log_diff);
        end
    endtask

    task automatic test_clean_run();
        bit seen;
        run_q.delete(); got_q.delete(); log_ready = 1'b0;
        for (int i = 0; i < 8; i++) run_q.push_back(mk_vec('0, OW'($urandom)));
        do_start();
        checks++; if (in_ready !== 1'b1 || busy !== 1'b1) begin
            errors++; $display("FAIL clean_run_ready got %b%b required 11", in_ready, busy);
        end
        send_run(0);
        wait_done(seen);
        checks++; if (seen !== 1'b1) begin errors++; $display("FAIL clean_done got 0 required 1"); end
        checks++; if (vec_count !== IW'(8)) begin errors++; $display("FAIL clean_vec_count got %0d required 8", vec_count); end
        checks++; if (err_count !== '0) begin errors++; $display("FAIL clean_err_count got %0d required 0", err_count); end
        checks++; if (pass !== 1'b1 || log_valid !== 1'b0) begin
            errors++; $display("FAIL clean_pass_log got %b%b required 10", pass, log_valid);
        end
        tick();
        checks++; if (done !== 1'b0 || pass !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL clean_done_pulse got %b%b%b required 010", done, pass, busy);
        end
    endtask

    task automatic test_masked_mismatch();
        bit seen;
        logic [OW-1:0] ones;
        ones = '1;
        run_q.delete(); got_q.delete(); log_ready = 1'b0;
        for (int i = 0; i < 8; i++)
            run_q.push_back(mk_vec(i == 3 ? OW'(4) : OW'(0), i == 3 ? (ones & ~OW'(4)) : ones));
        do_start(); send_run(1); wait_done(seen);
        checks++; if (seen !== 1'b1 || pass !== 1'b1 || err_count !== '0 || log_valid !== 1'b0) begin
            errors++; $display("FAIL masked_pass got done=%b pass=%b err=%0d lv=%b required 1 1 0 0",
                seen, pass, err_count, log_valid);
        end
        run_q[3].m = ones;
        do_start();
        for (int i = 0; i < 4; i++) send_vec(run_q[i], 1'b0);
        checks++; if (log_valid !== 1'b0) begin errors++; $display("FAIL mask_lat0 log_valid=%b required 0", log_valid); end
        tick();
        checks++; if (log_valid !== 1'b0) begin errors++; $display("FAIL mask_lat1 log_valid=%b required 0", log_valid); end
        tick();
        checks++; if (log_valid !== 1'b1 || log_idx !== IW'(3) || log_diff !== OW'(4)) begin
            errors++; $display("FAIL mask_lat2 got %b/%0h/%0h required 1/3/4", log_valid, log_idx, log_diff);
        end
        for (int i = 4; i < 8; i++) send_vec(run_q[i], i == 7);
        wait_done(seen);
        checks++; if (seen !== 1'b1 || err_count !== IW'(1) || first_err_valid !== 1'b1 || first_err_idx !== IW'(3) || pass !== 1'b0) begin
            errors++; $display("FAIL mask_all_ones got done=%b err=%0d fv=%b fidx=%0d pass=%b required 1 1 1 3 0",
                seen, err_count, first_err_valid, first_err_idx, pass);
        end
        drain_log();
    endtask

    task automatic test_backpressure();
        bit seen;
        run_q.delete(); got_q.delete(); log_ready = 1'b0;
        for (int i = 0; i < 20; i++) run_q.push_back(mk_vec(OW'($urandom) | OW'(1), '1));
        compute_model();
        do_start();
        for (int i = 0; i < 16; i++) send_vec(run_q[i], 1'b0);
        in_valid = 1'b1; dut_out = run_q[16].d; exp_out = run_q[16].e; care_mask = run_q[16].m;
        repeat (4) tick();
        checks++; if (in_ready !== 1'b0 || vec_count !== IW'(16)) begin
            errors++; $display("FAIL bp_stall got ready=%b vec=%0d required 0 16", in_ready, vec_count);
        end
        checks++; if (err_count !== IW'(16) || log_valid !== 1'b1 || got_q.size() != 0) begin
            errors++; $display("FAIL bp_held got err=%0d lv=%b popped=%0d required 16 1 0", err_count, log_valid, got_q.size());
        end
        log_ready = 1'b1;
        for (int i = 16; i < 20; i++) send_vec(run_q[i], i == 19);
        wait_done(seen);
        checks++; if (seen !== 1'b1 || err_count !== IW'(20) || vec_count !== IW'(20)) begin
            errors++; $display("FAIL bp_done got done=%b err=%0d vec=%0d required 1 20 20", seen, err_count, vec_count);
        end
        drain_log();
        checks++; if (got_q.size() != 20) begin errors++; $display("FAIL bp_rec_count got %0d required 20", got_q.size()); end
        for (int i = 0; i < got_q.size() && i < m_recs.size(); i++) begin
            checks++; if (got_q[i] !== m_recs[i]) begin
                errors++; $display("FAIL bp_rec[%0d] got %0h/%0h required %0h/%0h", i,
                    got_q[i].idx, got_q[i].diff, m_recs[i].idx, m_recs[i].diff);
            end
        end
    endtask

    task automatic test_first_error();
        bit seen;
        run_q.delete(); got_q.delete(); log_ready = 1'b1;
        for (int i = 0; i < 12; i++)
            run_q.push_back(mk_vec((i == 5 || i == 9) ? (OW'($urandom) | OW'(2)) : OW'(0), '1));
        compute_model();
        do_start(); send_run(2); wait_done(seen);
        checks++; if (seen !== 1'b1 || first_err_valid !== 1'b1 || first_err_idx !== IW'(5) || err_count !== IW'(2)) begin
            errors++; $display("FAIL first_err got done=%b fv=%b fidx=%0d err=%0d required 1 1 5 2",
                seen, first_err_valid, first_err_idx, err_count);
        end
        drain_log();
        checks++; if (got_q.size() != 2 || got_q[0] !== m_recs[0] || got_q[1] !== m_recs[1]) begin
            errors++; $display("FAIL first_err_recs got %0d records required 2 at idx 5,9", got_q.size());
        end
    endtask

    task automatic test_reset_mid_run();
        bit seen;
        run_q.delete(); got_q.delete(); log_ready = 1'b0;
        for (int i = 0; i < 4; i++) run_q.push_back(mk_vec(OW'(8), '1));
        do_start();
        for (int i = 0; i < 4; i++) send_vec(run_q[i], 1'b0);
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        checks++; if (vec_count !== '0 || log_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
            errors++; $display("FAIL midrst got vec=%0d lv=%b busy=%b rdy=%b required 0 0 0 0",
                vec_count, log_valid, busy, in_ready);
        end
        repeat (3) tick();
        checks++; if (log_valid !== 1'b0 || err_count !== '0 || first_err_valid !== 1'b0) begin
            errors++; $display("FAIL midrst_flush got lv=%b err=%0d fv=%b required 0 0 0", log_valid, err_count, first_err_valid);
        end
        run_q.delete();
        for (int i = 0; i < 5; i++) run_q.push_back(mk_vec(i == 2 ? OW'(1) : OW'(0), '1));
        compute_model();
        do_start(); send_run(1); wait_done(seen);
        checks++; if (seen !== 1'b1 || vec_count !== IW'(5) || err_count !== IW'(m_err) || first_err_idx !== IW'(m_fidx)) begin
            errors++; $display("FAIL midrst_rerun got done=%b vec=%0d err=%0d fidx=%0d required 1 5 %0d %0d",
                seen, vec_count, err_count, first_err_idx, m_err, m_fidx);
        end
        drain_log();
    endtask

    task automatic test_restart();
        bit seen;
        run_q.delete(); got_q.delete(); log_ready = 1'b0;
        for (int i = 0; i < 3; i++) run_q.push_back(mk_vec('0, '1));
        do_start();
        for (int i = 0; i < 3; i++) send_vec(run_q[i], 1'b0);
        do_start();
        checks++; if (busy !== 1'b1 || vec_count !== IW'(3) || in_ready !== 1'b1) begin
            errors++; $display("FAIL restart_ignored got busy=%b vec=%0d rdy=%b required 1 3 1", busy, vec_count, in_ready);
        end
        send_vec(mk_vec(OW'(16), '1), 1'b1);
        wait_done(seen);
        checks++; if (seen !== 1'b1 || vec_count !== IW'(4) || err_count !== IW'(1)) begin
            errors++; $display("FAIL restart_run got done=%b vec=%0d err=%0d required 1 4 1", seen, vec_count, err_count);
        end
        tick();
        checks++; if (log_valid !== 1'b1 || busy !== 1'b0 || log_idx !== IW'(3)) begin
            errors++; $display("FAIL restart_log_kept got lv=%b busy=%b idx=%0d required 1 0 3", log_valid, busy, log_idx);
        end
        do_start();
        checks++; if (vec_count !== '0 || err_count !== '0 || log_valid !== 1'b0 || first_err_valid !== 1'b0 || pass !== 1'b0) begin
            errors++; $display("FAIL restart_clear got vec=%0d err=%0d lv=%b fv=%b pass=%b required 0 0 0 0 0",
                vec_count, err_count, log_valid, first_err_valid, pass);
        end
        send_vec(mk_vec(OW'(32), '1), 1'b0);
        send_vec(mk_vec('0, '1), 1'b1);
        wait_done(seen);
        checks++; if (seen !== 1'b1 || log_idx !== '0 || log_diff !== OW'(32) || first_err_idx !== '0) begin
            errors++; $display("FAIL restart_idx got done=%b idx=%0d diff=%0h fidx=%0d required 1 0 20 0",
                seen, log_idx, log_diff, first_err_idx);
        end
        drain_log();
    endtask

    task automatic test_random();
        bit seen;
        bit lr;
        int unsigned len;
        logic [OW-1:0] flip, m;
        for (int r = 0; r < 12; r++) begin
            lr = r[0];
            len = lr ? $urandom_range(1, 40) : $urandom_range(1, 14);
            run_q.delete(); got_q.delete(); log_ready = lr;
            for (int unsigned i = 0; i < len; i++) begin
                case ($urandom_range(0, 3))
                    0:       flip = '0;
                    1:       flip = OW'(1) << $urandom_range(0, OW - 1);
                    2:       flip = OW'($urandom);
                    default: flip = '0;
                endcase
                case ($urandom_range(0, 2))
                    0:       m = '1;
                    1:       m = '0;
                    default: m = OW'($urandom);
                endcase
                run_q.push_back(mk_vec(flip, m));
            end
            compute_model();
            do_start(); send_run(2); wait_done(seen);
            checks++; if (seen !== 1'b1 || vec_count !== IW'(len) || err_count !== IW'(m_err)) begin
                errors++; $display("FAIL rand%0d_counts got done=%b vec=%0d err=%0d required 1 %0d %0d",
                    r, seen, vec_count, err_count, len, m_err);
            end
            checks++; if (first_err_valid !== m_fv || first_err_idx !== IW'(m_fidx) || pass !== m_pass) begin
                errors++; $display("FAIL rand%0d_first got fv=%b fidx=%0d pass=%b required %b %0d %b",
                    r, first_err_valid, first_err_idx, pass, m_fv, m_fidx, m_pass);
            end
            drain_log();
            checks++; if (got_q.size() != m_recs.size()) begin
                errors++; $display("FAIL rand%0d_nrec got %0d required %0d", r, got_q.size(), m_recs.size());
            end
            for (int i = 0; i < got_q.size() && i < m_recs.size(); i++) begin
                checks++; if (got_q[i] !== m_recs[i]) begin
                    errors++; $display("FAIL rand%0d_rec[%0d] got %0h/%0h required %0h/%0h", r, i,
                        got_q[i].idx, got_q[i].diff, m_recs[i].idx, m_recs[i].diff);
                end
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        dut_out = '0; exp_out = '0; care_mask = '0; log_ready = 1'b0;
        test_reset();
        test_clean_run();
        test_masked_mismatch();
        test_backpressure();
        test_first_error();
        test_reset_mid_run();
        test_restart();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
